// File: rtl/l2_snoop_responder_pkg.sv
// Shared definitions for the L2 snoop responder slice.
// Contents: size defaults, MESI / snoop-op / snoop-result encodings, the
// responder FSM state type and the per-op MESI transition decoder.
// No ports; imported by l2_way_match and l2_snoop_responder.
package l2_snoop_responder_pkg;

  localparam int INDEX_SIZE    = 14;
  localparam int TAG_SIZE      = 12;
  localparam int ASSOCIATIVITY = 8;
  localparam int COUNTER_SIZE  = 3;

  localparam logic [1:0] MESI_M = 2'b00;
  localparam logic [1:0] MESI_E = 2'b01;
  localparam logic [1:0] MESI_S = 2'b10;
  localparam logic [1:0] MESI_I = 2'b11;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INV   = 2'b10;
  localparam logic [1:0] OP_RWIM  = 2'b11;

  localparam logic [1:0] RSP_NOHIT = 2'b00;
  localparam logic [1:0] RSP_HIT   = 2'b01;
  localparam logic [1:0] RSP_HITM  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_COMPARE,
    ST_WB,
    ST_UPDATE
  } state_t;

  typedef struct packed {
    logic [1:0] result;
    logic [1:0] mesi;
    logic       wr;
    logic       err;
  } snoop_action_t;

  // Response, next MESI state, write strobe and error flag for one snooped op.
  // A WRITE snoop hitting any valid line, or an INVALIDATE hitting M/E, means
  // another cache believes it owns a line we also hold: flag it, change nothing.
  function automatic snoop_action_t decode_snoop(input logic [1:0] op,
                                                 input logic       hit,
                                                 input logic [1:0] mesi,
                                                 input logic       multi);
    snoop_action_t a;
    a.result = RSP_NOHIT;
    a.mesi   = mesi;
    a.err    = multi;
    a.wr     = 1'b0;
    if (hit) begin
      case (op)
        OP_READ: begin
          a.result = (mesi == MESI_M) ? RSP_HITM : RSP_HIT;
          a.mesi   = MESI_S;
        end
        OP_RWIM: begin
          a.result = (mesi == MESI_M) ? RSP_HITM : RSP_HIT;
          a.mesi   = MESI_I;
        end
        OP_INV: begin
          if (mesi == MESI_S) begin
            a.result = RSP_HIT;
            a.mesi   = MESI_I;
          end else begin
            a.err = 1'b1;
          end
        end
        default: a.err = 1'b1;
      endcase
    end
    a.wr = hit && (a.mesi != mesi);
    return a;
  endfunction

endpackage

// File: rtl/l2_way_match.sv
// Combinational tag match across all ways of one set.
// Ports:
//   tag       in   TAG_BITS              tag being snooped
//   set_data  in   WAYS*(TAG_BITS+2)     way w = {mesi[1:0], tag}
//   hit       out  1                     some valid way matched
//   way       out  WAY_BITS              lowest matching way
//   mesi      out  2                     MESI state of that way
//   multi_hit out  1                     more than one valid way matched
module l2_way_match
  import l2_snoop_responder_pkg::*;
#(
  parameter int TAG_BITS = TAG_SIZE,
  parameter int WAYS     = ASSOCIATIVITY,
  parameter int WAY_BITS = COUNTER_SIZE
) (
  input  logic [TAG_BITS-1:0]          tag,
  input  logic [WAYS*(TAG_BITS+2)-1:0] set_data,
  output logic                         hit,
  output logic [WAY_BITS-1:0]          way,
  output logic [1:0]                   mesi,
  output logic                         multi_hit
);

  localparam int EW = TAG_BITS + 2;

  logic [WAYS-1:0] match;

  // case compares exactly, so an unknown (xx) state falls to the default and
  // the way can never match.
  function automatic logic entry_valid(input logic [1:0] m);
    case (m)
      MESI_M, MESI_E, MESI_S: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  always_comb begin
    match = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = entry_valid(set_data[w*EW+TAG_BITS +: 2]) &&
                 (set_data[w*EW +: TAG_BITS] == tag);
    end
  end

  // Scan from the top so the lowest matching way is the one left selected.
  always_comb begin
    hit       = 1'b0;
    way       = '0;
    mesi      = MESI_I;
    multi_hit = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) begin
        multi_hit = multi_hit | hit;
        hit       = 1'b1;
        way       = WAY_BITS'(w);
        mesi      = set_data[w*EW+TAG_BITS +: 2];
      end
    end
  end

endmodule

// File: rtl/l2_snoop_responder.sv
// Responder for snooped L2 bus ops: reads the addressed set, matches the tag,
// answers NOHIT/HIT/HITM, hands modified lines to the writeback path and
// updates the way's MESI state. One op in flight; 3-cycle latency from accept
// to response, plus however long the writeback handshake takes on HITM.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   snp_valid/snp_ready/snp_op/snp_addr   snoop request ({tag,index})
//   tag_rd_en/tag_rd_index/tag_rd_data    set read, data one cycle later
//   tag_wr_en/tag_wr_index/tag_wr_way/tag_wr_mesi   MESI update strobe
//   wb_req/wb_index/wb_way/wb_ack         writeback handshake (HITM only)
//   rsp_valid/rsp_result                  one-cycle snoop result
//   protocol_err                          one-cycle pulse, illegal state/multi-hit
// Optional (macro SNOOP_STATS_EN): stat_hit, stat_hitm saturating counters.
module l2_snoop_responder
  import l2_snoop_responder_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_SIZE,
  parameter int TAG_BITS   = TAG_SIZE,
  parameter int WAYS       = ASSOCIATIVITY,
  parameter int WAY_BITS   = COUNTER_SIZE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           snp_valid,
  output logic                           snp_ready,
  input  logic [1:0]                     snp_op,
  input  logic [TAG_BITS+INDEX_BITS-1:0] snp_addr,
  output logic                           tag_rd_en,
  output logic [INDEX_BITS-1:0]          tag_rd_index,
  input  logic [WAYS*(TAG_BITS+2)-1:0]   tag_rd_data,
  output logic                           tag_wr_en,
  output logic [INDEX_BITS-1:0]          tag_wr_index,
  output logic [WAY_BITS-1:0]            tag_wr_way,
  output logic [1:0]                     tag_wr_mesi,
  output logic                           wb_req,
  output logic [INDEX_BITS-1:0]          wb_index,
  output logic [WAY_BITS-1:0]            wb_way,
  input  logic                           wb_ack,
  output logic                           rsp_valid,
  output logic [1:0]                     rsp_result,
  output logic                           protocol_err
`ifdef SNOOP_STATS_EN
  ,
  output logic [15:0]                    stat_hit,
  output logic [15:0]                    stat_hitm
`endif
);

  state_t state_q, state_d;

  logic [1:0]                     op_p0;
  logic [TAG_BITS+INDEX_BITS-1:0] addr_p0;
  logic [INDEX_BITS-1:0]          idx_p0;
  logic [TAG_BITS-1:0]            tag_p0;

  logic                m_hit, m_multi;
  logic [WAY_BITS-1:0] m_way;
  logic [1:0]          m_mesi;
  snoop_action_t       act_d;

  logic [WAY_BITS-1:0] way_p2;
  snoop_action_t       act_p2;

  assign idx_p0 = addr_p0[INDEX_BITS-1:0];
  assign tag_p0 = addr_p0[TAG_BITS+INDEX_BITS-1:INDEX_BITS];

  l2_way_match #(
    .TAG_BITS (TAG_BITS),
    .WAYS     (WAYS),
    .WAY_BITS (WAY_BITS)
  ) u_way_match (
    .tag       (tag_p0),
    .set_data  (tag_rd_data),
    .hit       (m_hit),
    .way       (m_way),
    .mesi      (m_mesi),
    .multi_hit (m_multi)
  );

  assign act_d = decode_snoop(op_p0, m_hit, m_mesi, m_multi);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Stage p0: capture the op on accept.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && snp_valid) begin
      op_p0   <= snp_op;
      addr_p0 <= snp_addr;
    end
  end

  // Stage p2: freeze match and decision at the end of COMPARE; WB and UPDATE
  // work only from these registers, so the set data may change meanwhile.
  always_ff @(posedge clk) begin
    if (state_q == ST_COMPARE) begin
      way_p2 <= m_way;
      act_p2 <= act_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (snp_valid) state_d = ST_LOOKUP;
      ST_LOOKUP:  state_d = ST_COMPARE;
      ST_COMPARE: state_d = (act_d.result == RSP_HITM) ? ST_WB : ST_UPDATE;
      ST_WB:      if (wb_ack) state_d = ST_UPDATE;
      ST_UPDATE:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Index/way outputs are forced to zero outside their strobe so nothing
  // stale from a previous op is visible on the buses.
  assign snp_ready    = (state_q == ST_IDLE);
  assign tag_rd_en    = (state_q == ST_LOOKUP);
  assign tag_rd_index = tag_rd_en ? idx_p0 : '0;

  assign wb_req   = (state_q == ST_WB);
  assign wb_index = wb_req ? idx_p0 : '0;
  assign wb_way   = wb_req ? way_p2 : '0;

  assign rsp_valid    = (state_q == ST_UPDATE);
  assign rsp_result   = rsp_valid ? act_p2.result : RSP_NOHIT;
  assign protocol_err = rsp_valid && act_p2.err;
  assign tag_wr_en    = rsp_valid && act_p2.wr;
  assign tag_wr_index = tag_wr_en ? idx_p0 : '0;
  assign tag_wr_way   = tag_wr_en ? way_p2 : '0;
  assign tag_wr_mesi  = tag_wr_en ? act_p2.mesi : 2'b00;

`ifdef SNOOP_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hit  <= '0;
      stat_hitm <= '0;
    end else if (rsp_valid) begin
      if (act_p2.result == RSP_HIT)  stat_hit  <= sat_inc16(stat_hit);
      if (act_p2.result == RSP_HITM) stat_hitm <= sat_inc16(stat_hitm);
    end
  end
`endif

endmodule

// File: tb/tb_l2_snoop_responder.sv
// Self-checking bench for l2_snoop_responder. Models the tag/MESI array
// behaviourally and scores every snoop response against expectations queued
// when the op is issued. Build with SNOOP_STATS_EN to also check the counters.
module tb_l2_snoop_responder;
  import l2_snoop_responder_pkg::*;

  localparam int IB = 14;
  localparam int TB = 12;
  localparam int NW = 8;
  localparam int EW = TB + 2;

  logic           clk = 1'b0;
  logic           rst, snp_valid, snp_ready;
  logic [1:0]     snp_op;
  logic [TB+IB-1:0] snp_addr;
  logic           tag_rd_en;
  logic [IB-1:0]  tag_rd_index;
  logic [NW*EW-1:0] tag_rd_data = '0;
  logic           tag_wr_en;
  logic [IB-1:0]  tag_wr_index;
  logic [2:0]     tag_wr_way;
  logic [1:0]     tag_wr_mesi;
  logic           wb_req;
  logic [IB-1:0]  wb_index;
  logic [2:0]     wb_way;
  logic           wb_ack;
  logic           rsp_valid;
  logic [1:0]     rsp_result;
  logic           protocol_err;
`ifdef SNOOP_STATS_EN
  logic [15:0]    stat_hit, stat_hitm;
`endif

  int checks = 0;
  int errors = 0;
  int exp_hit = 0;
  int exp_hitm = 0;

  typedef struct {
    logic [1:0]    result;
    logic          wr;
    logic [2:0]    way;
    logic [1:0]    mesi;
    logic          err;
    logic          wb;
    logic [IB-1:0] idx;
  } exp_t;

  exp_t sb[$];
  logic [NW*EW-1:0] mem [int unsigned];
  logic [NW*EW-1:0] wr_set;

  always #5 clk = ~clk;

  l2_snoop_responder dut (
    .clk          (clk),
    .rst          (rst),
    .snp_valid    (snp_valid),
    .snp_ready    (snp_ready),
    .snp_op       (snp_op),
    .snp_addr     (snp_addr),
    .tag_rd_en    (tag_rd_en),
    .tag_rd_index (tag_rd_index),
    .tag_rd_data  (tag_rd_data),
    .tag_wr_en    (tag_wr_en),
    .tag_wr_index (tag_wr_index),
    .tag_wr_way   (tag_wr_way),
    .tag_wr_mesi  (tag_wr_mesi),
    .wb_req       (wb_req),
    .wb_index     (wb_index),
    .wb_way       (wb_way),
    .wb_ack       (wb_ack),
    .rsp_valid    (rsp_valid),
    .rsp_result   (rsp_result),
    .protocol_err (protocol_err)
`ifdef SNOOP_STATS_EN
    ,
    .stat_hit     (stat_hit),
    .stat_hitm    (stat_hitm)
`endif
  );

  function automatic logic [NW*EW-1:0] get_set(input int unsigned i);
    logic [NW*EW-1:0] s;
    if (mem.exists(i)) return mem[i];
    for (int w = 0; w < NW; w++) s[w*EW +: EW] = {MESI_I, 12'h000};
    return s;
  endfunction

  task automatic set_way(input int unsigned i, input int w, input logic [11:0] tag,
                         input logic [1:0] mesi);
    logic [NW*EW-1:0] s;
    s = get_set(i);
    s[w*EW +: EW] = {mesi, tag};
    mem[i] = s;
  endtask

  // Tag array model: registered read, MESI write on strobe.
  always @(posedge clk) begin
    if (tag_rd_en) tag_rd_data <= get_set(tag_rd_index);
    if (tag_wr_en) begin
      wr_set = get_set(tag_wr_index);
      wr_set[tag_wr_way*EW+TB +: 2] = tag_wr_mesi;
      mem[tag_wr_index] = wr_set;
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [11:0] tag, input logic [IB-1:0] idx,
                        input int ack_delay, input bit hold,
                        input logic [1:0] e_res, input logic e_wr, input logic [2:0] e_way,
                        input logic [1:0] e_mesi, input logic e_err, input logic e_wb);
    exp_t e, x;
    int cyc, wb_seen, rd_seen;
    bit done, stray, wb_bad;
    e.result = e_res; e.wr = e_wr; e.way = e_way; e.mesi = e_mesi;
    e.err = e_err; e.wb = e_wb; e.idx = idx;
    sb.push_back(e);
    if (e_res == RSP_HIT) exp_hit++;
    if (e_res == RSP_HITM) exp_hitm++;

    checks++;
    if (snp_ready !== 1'b1) begin
      errors++; $display("FAIL ready_idle: snp_ready=%b required 1", snp_ready);
    end
    snp_valid = 1'b1; snp_op = op; snp_addr = {tag, idx};
    @(posedge clk); #1;
    if (!hold) snp_valid = 1'b0;

    checks++;
    if (tag_rd_en !== 1'b1 || tag_rd_index !== idx) begin
      errors++; $display("FAIL lookup_rd: tag_rd_en=%b index=%0d required 1/%0d",
                         tag_rd_en, tag_rd_index, idx);
    end

    cyc = 1; wb_seen = 0; rd_seen = 0; done = 0; stray = 0; wb_bad = 0;
    while (cyc <= 30) begin
      if (tag_rd_en === 1'b1) rd_seen++;
      if (rsp_valid === 1'b1) begin
        done = 1;
        break;
      end
      if (tag_wr_en === 1'b1 || protocol_err === 1'b1) stray = 1;
      if (wb_req === 1'b1) begin
        wb_seen++;
        if (!e_wb || wb_index !== idx || wb_way !== e_way) wb_bad = 1;
        wb_ack = (wb_seen == ack_delay);
      end else begin
        wb_ack = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    wb_ack = 1'b0;
    snp_valid = 1'b0;

    x = sb.pop_front();
    checks++;
    if (!done) begin
      errors++; $display("FAIL rsp_timeout: no rsp_valid within %0d cycles", cyc);
    end else begin
      if (cyc != 3 + wb_seen) begin
        errors++; $display("FAIL latency: rsp at cycle %0d required %0d", cyc, 3 + wb_seen);
      end
      checks++;
      if (rsp_result !== x.result) begin
        errors++; $display("FAIL rsp_result: got %b required %b", rsp_result, x.result);
      end
      checks++;
      if (tag_wr_en !== x.wr) begin
        errors++; $display("FAIL tag_wr_en: got %b required %b", tag_wr_en, x.wr);
      end
      if (x.wr) begin
        checks++;
        if (tag_wr_index !== x.idx || tag_wr_way !== x.way || tag_wr_mesi !== x.mesi) begin
          errors++; $display("FAIL tag_wr: index=%0d way=%0d mesi=%b required %0d/%0d/%b",
                             tag_wr_index, tag_wr_way, tag_wr_mesi, x.idx, x.way, x.mesi);
        end
      end
      checks++;
      if (protocol_err !== x.err) begin
        errors++; $display("FAIL protocol_err: got %b required %b", protocol_err, x.err);
      end
    end
    checks++;
    if ((wb_seen > 0) !== x.wb || wb_bad) begin
      errors++; $display("FAIL wb_req: cycles=%0d bad_fields=%0d required wb=%b", wb_seen, wb_bad, x.wb);
    end
    checks++;
    if (stray || rd_seen != 1) begin
      errors++; $display("FAIL side_strobes: stray=%0d reads=%0d required 0/1", stray, rd_seen);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || snp_ready !== 1'b1) begin
      errors++; $display("FAIL rsp_pulse: rsp_valid=%b snp_ready=%b required 0/1", rsp_valid, snp_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; snp_valid = 1'b0; snp_op = 2'b00; snp_addr = '0; wb_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (snp_ready !== 1'b1 || tag_rd_en !== 1'b0 || tag_wr_en !== 1'b0 || wb_req !== 1'b0 ||
        rsp_valid !== 1'b0 || rsp_result !== 2'b00 || protocol_err !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: ready=%b rd=%b wr=%b wb=%b rsp=%b res=%b err=%b",
                         snp_ready, tag_rd_en, tag_wr_en, wb_req, rsp_valid, rsp_result, protocol_err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (snp_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: ready=%b rsp=%b required 1/0", snp_ready, rsp_valid);
    end
`ifdef SNOOP_STATS_EN
    checks++;
    if (stat_hit !== 16'd0 || stat_hitm !== 16'd0) begin
      errors++; $display("FAIL stats_reset: hit=%0d hitm=%0d required 0/0", stat_hit, stat_hitm);
    end
`endif
  endtask

  task automatic test_read_miss();
    run_op(OP_READ, 12'h123, 14'd3, 0, 0, RSP_NOHIT, 1'b0, 3'd0, MESI_I, 1'b0, 1'b0);
  endtask

  task automatic test_read_excl();
    set_way(5, 2, 12'h03A, MESI_E);
    run_op(OP_READ, 12'h03A, 14'd5, 0, 0, RSP_HIT, 1'b1, 3'd2, MESI_S, 1'b0, 1'b0);
  endtask

  task automatic test_rwim_modified();
    set_way(7, 6, 12'h1F0, MESI_M);
    run_op(OP_RWIM, 12'h1F0, 14'd7, 4, 0, RSP_HITM, 1'b1, 3'd6, MESI_I, 1'b0, 1'b1);
  endtask

  task automatic test_invalidate();
    set_way(11, 1, 12'h02B, MESI_S);
    run_op(OP_INV, 12'h02B, 14'd11, 0, 0, RSP_HIT, 1'b1, 3'd1, MESI_I, 1'b0, 1'b0);
    run_op(OP_INV, 12'h02B, 14'd11, 0, 0, RSP_NOHIT, 1'b0, 3'd0, MESI_I, 1'b0, 1'b0);
  endtask

  task automatic test_multi_hit();
    set_way(20, 0, 12'h044, MESI_E);
    set_way(20, 4, 12'h044, MESI_E);
    run_op(OP_READ, 12'h044, 14'd20, 0, 0, RSP_HIT, 1'b1, 3'd0, MESI_S, 1'b1, 1'b0);
  endtask

  task automatic test_protocol_err();
    // Line at set 5 way 2 is now S after test_read_excl.
    run_op(OP_WRITE, 12'h03A, 14'd5, 0, 0, RSP_NOHIT, 1'b0, 3'd0, MESI_I, 1'b1, 1'b0);
    set_way(30, 3, 12'h077, MESI_E);
    run_op(OP_INV, 12'h077, 14'd30, 0, 0, RSP_NOHIT, 1'b0, 3'd0, MESI_I, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    set_way(40, 5, 12'hABC, MESI_S);
    run_op(OP_READ, 12'hABC, 14'd40, 0, 1, RSP_HIT, 1'b0, 3'd0, MESI_S, 1'b0, 1'b0);
    run_op(OP_RWIM, 12'hABC, 14'd40, 0, 1, RSP_HIT, 1'b1, 3'd5, MESI_I, 1'b0, 1'b0);
  endtask

  task automatic test_wb_first_ack();
    wb_ack = 1'b1;
    @(posedge clk); #1;
    wb_ack = 1'b0;
    set_way(50, 7, 12'hFFF, MESI_M);
    run_op(OP_READ, 12'hFFF, 14'd50, 1, 0, RSP_HITM, 1'b1, 3'd7, MESI_S, 1'b0, 1'b1);
  endtask

  task automatic test_reset_in_wb();
    int n;
    bit seen, bad;
    logic [NW*EW-1:0] s;
    set_way(9, 6, 12'h055, MESI_M);
    snp_valid = 1'b1; snp_op = OP_READ; snp_addr = {12'h055, 14'd9};
    @(posedge clk); #1;
    snp_valid = 1'b0;
    seen = 0;
    for (n = 0; n < 10 && !seen; n++) begin
      if (wb_req === 1'b1) seen = 1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rst_wb_enter: wb_req=%b required 1 within 10 cycles", wb_req);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_hit = 0; exp_hitm = 0;
    checks++;
    if (wb_req !== 1'b0 || snp_ready !== 1'b1 || rsp_valid !== 1'b0 || tag_wr_en !== 1'b0) begin
      errors++; $display("FAIL rst_in_wb: wb=%b ready=%b rsp=%b wr=%b required 0/1/0/0",
                         wb_req, snp_ready, rsp_valid, tag_wr_en);
    end
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || tag_wr_en !== 1'b0 || wb_req !== 1'b0) bad = 1;
    end
    s = get_set(9);
    checks++;
    if (bad || s[6*EW+TB +: 2] !== MESI_M) begin
      errors++; $display("FAIL rst_drop: late_activity=%0d mesi=%b required 0/00", bad, s[6*EW+TB +: 2]);
    end
    run_op(OP_READ, 12'h055, 14'd9, 2, 0, RSP_HITM, 1'b1, 3'd6, MESI_S, 1'b0, 1'b1);
  endtask

`ifdef SNOOP_STATS_EN
  task automatic test_stats();
    checks++;
    if (stat_hit !== 16'(exp_hit) || stat_hitm !== 16'(exp_hitm)) begin
      errors++; $display("FAIL stats: hit=%0d hitm=%0d required %0d/%0d",
                         stat_hit, stat_hitm, exp_hit, exp_hitm);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_miss();
    test_read_excl();
    test_rwim_modified();
    test_invalidate();
    test_multi_hit();
    test_protocol_err();
    test_back_to_back();
    test_wb_first_ack();
`ifdef SNOOP_STATS_EN
    test_stats();
`endif
    test_reset_in_wb();
`ifdef SNOOP_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
